uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
- Parametrised successor to the existing 8N1 UART receiver, for the control/debug UART path.
- Adds configurable data width, optional even/odd parity and 1 or 2 stop bits.
- Adds input synchronisation, 3-sample majority voting, false-start rejection, framing/parity error flags and break detection.
- Driven by the shared baud oversampling tick s_tck. Delivers one-cycle-strobed bytes to the command parser.

Parameters:
- DBIT, 8, data bits per frame; legal 5..9.
- OVS, 16, s_tck ticks per bit; even, legal 8..32.
- PARITY_EN, 0, 1 = parity bit present after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- SB_BITS, 1, stop bits; legal 1 or 2.
- SYNC_STAGES, 2, flops in the rx synchroniser; legal >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx  input  1  serial line, asynchronous, idle high
- s_tck  input  1  oversampling tick, one clk wide, OVS per bit period
- rx_done_tck  output  1  one-cycle strobe: frame complete; dout and flags updated this cycle
- dout  output  DBIT  received data, LSB = first bit on line
- parity_err  output  1  parity mismatch in the last frame
- frame_err  output  1  a stop bit was sampled low in the last frame
- break_det  output  1  last frame was a break condition
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all counters, the shift register and the synchroniser are set to 1 (synchroniser) or 0 (everything else).
  - dout = 0; rx_done_tck, parity_err, frame_err, break_det and busy = 0.
  - Reset mid-frame abandons the frame. No strobe is emitted.
- Synchronised line rxs:
  - rx passes through SYNC_STAGES flops.
  - Sampled bit value = majority of rxs at tick counts OVS/2-1, OVS/2 and OVS/2+1 within the bit.
- Tick counter s counts 0..OVS-1 on s_tck and wraps to 0 at the end of each bit. Width $clog2(OVS).
- States and transitions:
  - IDLE: when rxs = 0, clear s and go to START. This happens on any clk; s_tck is not required.
  - START: at s = OVS/2+1, vote the start bit.
    - Vote = 1 → glitch; return to IDLE with no strobe.
    - Vote = 0 → continue to s = OVS-1, then go to DATA with n = 0.
  - DATA: vote each bit at s = OVS/2+1 and shift it in LSB-first. At s = OVS-1: if n = DBIT-1, go to PARITY (PARITY_EN=1) or STOP; otherwise increment n.
  - PARITY: vote at s = OVS/2+1. Expected bit = XOR of the data bits, inverted when PARITY_ODD=1. Latch the mismatch. Go to STOP at s = OVS-1.
  - STOP: vote each stop bit at s = OVS/2+1; any 0 sets pending frame error.
    - On the last stop bit, at its s = OVS/2+1 tick, raise rx_done_tck for exactly one clk. On that same clk, update dout, parity_err, frame_err and break_det.
    - Then go to IDLE, or to BRK_WAIT if a break was detected. Completing half a bit early allows back-to-back frames.
  - BRK_WAIT: wait until rxs = 1, then go to IDLE. No strobe is emitted in this state.
- Break: break_det = 1 when all data bits = 0, the parity bit (if present) = 0 and the first stop bit = 0. frame_err is also set in this case.
- Output holding: dout and the three flags hold their values until the next rx_done_tck.
- Parity gating: parity_err is always 0 when PARITY_EN=0.
- Coincident events: an s_tck arriving on the same clk as the IDLE→START transition is not counted.
- Timing: s_tck must be at least 2 clks apart. Behaviour with s_tck stuck high is undefined.

Decomposition:
- Package uart_pkg:
  - state encoding: IDLE, START, DATA, PARITY, STOP, BRK_WAIT; 3-bit enum.
  - parity mode constants.
  - helper function computing counter widths.
- One sub-module, uart_rx_sync: SYNC_STAGES synchroniser plus 3-sample majority voter. Interface: rxs out, vote-sample enables in, vote out.

Test Plan:
All scenarios use OVS=16 and s_tck every 4 clks.
- Frame 0x55, 8N1 → exactly one rx_done_tck, dout = 0x55, all flags 0, busy low 2 clks later.
- Start pulse only 3 ticks low → no rx_done_tck, busy returns to 0, next valid frame 0xC3 is received correctly.
- PARITY_EN=1, even parity, frame 0xA3 sent with parity bit 1 (wrong) → dout = 0xA3, parity_err = 1. Re-send with parity bit 0 → parity_err = 0.
- Frame 0x7E with the stop bit driven low → frame_err = 1, break_det = 0, dout = 0x7E.
- rx held low for 12 bit times → one strobe with dout = 0x00, break_det = 1, frame_err = 1. No further strobe until rx goes high; the following frame 0x11 is received correctly.
- Single-tick low spike at mid-bit of data bit 3 in 0xFF → dout = 0xFF (majority rejects the spike).
- reset pulsed low during data bit 4 → outputs zero immediately, no strobe. The next frame 0x96 is received correctly. Repeat with SB_BITS=2 and DBIT=7.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: FSM encoding, parity sense, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Receiver FSM encoding (3 bits, IDLE must stay zero so busy = |state is also valid).
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    // Value XORed into the data parity to form the expected parity bit.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the async rx line plus 3-sample majority voter.
// Latency: SYNC_STAGES clks from i_rx to o_rxs; o_vote is combinational on the third sample.
// Backpressure: none; samples are taken whenever i_samp_en is high.
//
// Ports:
//   clk, reset   - core clock, async active-low reset (synchroniser resets to idle-high)
//   i_rx         - raw serial line
//   i_samp_en    - capture o_rxs into the two-entry sample history (first two of three samples)
//   o_rxs        - synchronised line
//   o_vote       - majority of the two stored samples and the current o_rxs
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_rx,
    input  logic i_samp_en,
    output logic o_rxs,
    output logic o_vote
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_samp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '1;
            r_samp <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            if (i_samp_en) begin
                r_samp <= {r_samp[0], o_rxs};
            end
        end
    end

    assign o_rxs = r_sync[SYNC_STAGES-1];

    // The third sample is the live synchronised value, so the vote is ready on the
    // same tick that would otherwise have stored it.
    assign o_vote = (r_samp[1] & r_samp[0]) | (r_samp[1] & o_rxs) | (r_samp[0] & o_rxs);

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampled UART receiver: DBIT data bits LSB-first, optional even/odd parity, 1 or 2 stop bits, break detect.
// Latency: rx_done_tck fires on the vote tick (mid-bit + 1) of the last stop bit, plus SYNC_STAGES clks of input sync.
// Backpressure: none; the consumer must take dout on rx_done_tck, outputs then hold until the next frame.
//
// Ports:
//   clk, reset   - system clock, async active-low reset
//   rx           - async serial line, idle high
//   s_tck        - oversampling tick, one clk wide, OVS ticks per bit
//   rx_done_tck  - one-clk strobe: frame complete, dout and flags updated this cycle
//   dout         - received data, LSB = first bit on the line
//   parity_err   - parity mismatch in last frame (always 0 without a parity bit)
//   frame_err    - a stop bit was sampled low in last frame
//   break_det    - last frame was all zeros through the first stop bit
//   busy         - FSM is not idle
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int OVS         = 16,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SB_BITS     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tck,
    output logic            rx_done_tck,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            busy
);

    localparam int SW = cnt_width(OVS);
    localparam int NW = cnt_width(DBIT);

    // Tick positions inside one bit period.
    localparam logic [SW-1:0] S_EARLY = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_MID   = SW'(OVS / 2);
    localparam logic [SW-1:0] S_VOTE  = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_LAST  = SW'(OVS - 1);

    localparam logic [NW-1:0] N_DLAST = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_SLAST = NW'(SB_BITS - 1);

    localparam logic HAS_PAR   = (PARITY_EN != 0);
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_e       r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;          // data bit index, reused as stop bit index
    logic [DBIT-1:0] r_shift;
    logic            r_par_bit;
    logic            r_par_err;
    logic            r_stop_err;   // a non-final stop bit was low
    logic            r_stop0_low;  // first stop bit was low (break qualifier)

    logic            r_done;
    logic [DBIT-1:0] r_dout;
    logic            r_pe;
    logic            r_fe;
    logic            r_brk;

    logic            w_rxs;
    logic            w_vote;
    logic            w_samp_en;
    logic            w_vote_tck;
    logic            w_last_tck;
    logic            w_stop0_low;
    logic            w_brk;

    assign w_samp_en  = s_tck && (r_state != ST_IDLE) && ((r_s == S_EARLY) || (r_s == S_MID));
    assign w_vote_tck = s_tck && (r_s == S_VOTE);
    assign w_last_tck = s_tck && (r_s == S_LAST);

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .i_rx      (rx),
        .i_samp_en (w_samp_en),
        .o_rxs     (w_rxs),
        .o_vote    (w_vote)
    );

    // With one stop bit the first stop bit is the one being voted right now.
    assign w_stop0_low = (r_n == '0) ? ~w_vote : r_stop0_low;
    // r_par_bit stays 0 when there is no parity bit, so it never blocks a break.
    assign w_brk       = (r_shift == '0) && !r_par_bit && w_stop0_low;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
            r_stop_err  <= 1'b0;
            r_stop0_low <= 1'b0;
            r_done      <= 1'b0;
            r_dout      <= '0;
            r_pe        <= 1'b0;
            r_fe        <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Tick counter only runs outside IDLE; a tick coincident with the
            // start edge is therefore not counted.
            if ((r_state != ST_IDLE) && s_tck) begin
                r_s <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_s <= '0;
                    if (!w_rxs) begin
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_vote_tck && w_vote) begin
                        r_state <= ST_IDLE;          // glitch, not a real start bit
                    end else if (w_last_tck) begin
                        r_state <= ST_DATA;
                        r_n     <= '0;
                    end
                end

                ST_DATA: begin
                    if (w_vote_tck) begin
                        r_shift <= {w_vote, r_shift[DBIT-1:1]};
                    end
                    if (w_last_tck) begin
                        if (r_n == N_DLAST) begin
                            r_n        <= '0;
                            r_stop_err <= 1'b0;
                            r_par_bit  <= 1'b0;
                            r_par_err  <= 1'b0;
                            r_state    <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            r_n <= r_n + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_vote_tck) begin
                        r_par_bit <= w_vote;
                        r_par_err <= w_vote ^ (^r_shift) ^ PAR_SENSE;
                    end
                    if (w_last_tck) begin
                        r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_vote_tck) begin
                        if (r_n == '0) begin
                            r_stop0_low <= ~w_vote;
                        end
                        if (r_n == N_SLAST) begin
                            // Finish at mid-bit so a following start edge is not missed.
                            r_done  <= 1'b1;
                            r_dout  <= r_shift;
                            r_pe    <= HAS_PAR && r_par_err;
                            r_fe    <= r_stop_err | ~w_vote;
                            r_brk   <= w_brk;
                            r_state <= w_brk ? ST_BRK_WAIT : ST_IDLE;
                        end else begin
                            r_stop_err <= r_stop_err | ~w_vote;
                        end
                    end
                    if (w_last_tck) begin
                        r_n <= r_n + 1'b1;
                    end
                end

                ST_BRK_WAIT: begin
                    // Hold off until the line releases so a long break yields one frame.
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_done_tck = r_done;
    assign dout        = r_dout;
    assign parity_err  = r_pe;
    assign frame_err   = r_fe;
    assign break_det   = r_brk;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: three instances (8N1, 8E1, 7N2) on separately muxed lines.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_rx_ext;

    localparam int BT = 64;   // clks per bit: OVS=16, s_tck every 4 clks

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic s_tck;
    logic line;
    int   sel;
    logic rx_a, rx_b, rx_c;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;
    assign rx_c = (sel == 2) ? line : 1'b1;

    logic       done_a, pe_a, fe_a, brk_a, busy_a;
    logic [7:0] dout_a;
    logic       done_b, pe_b, fe_b, brk_b, busy_b;
    logic [7:0] dout_b;
    logic       done_c, pe_c, fe_c, brk_c, busy_c;
    logic [6:0] dout_c;

    uart_rx_ext u_dut_a (
        .clk (clk), .reset (reset), .rx (rx_a), .s_tck (s_tck),
        .rx_done_tck (done_a), .dout (dout_a), .parity_err (pe_a),
        .frame_err (fe_a), .break_det (brk_a), .busy (busy_a)
    );

    uart_rx_ext #(.PARITY_EN (1), .PARITY_ODD (0)) u_dut_b (
        .clk (clk), .reset (reset), .rx (rx_b), .s_tck (s_tck),
        .rx_done_tck (done_b), .dout (dout_b), .parity_err (pe_b),
        .frame_err (fe_b), .break_det (brk_b), .busy (busy_b)
    );

    uart_rx_ext #(.DBIT (7), .SB_BITS (2)) u_dut_c (
        .clk (clk), .reset (reset), .rx (rx_c), .s_tck (s_tck),
        .rx_done_tck (done_c), .dout (dout_c), .parity_err (pe_c),
        .frame_err (fe_c), .break_det (brk_c), .busy (busy_c)
    );

    // Strobe counters per instance.
    int cnt_a, cnt_b, cnt_c;
    always @(posedge clk) begin
        if (done_a === 1'b1) cnt_a <= cnt_a + 1;
        if (done_b === 1'b1) cnt_b <= cnt_b + 1;
        if (done_c === 1'b1) cnt_c <= cnt_c + 1;
    end

    // Oversampling tick: one clk high every 4 clks.
    initial begin
        s_tck = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tck = 1'b1;
            @(negedge clk);
            s_tck = 1'b0;
        end
    end

    int n_vec;
    int n_bad;
    int c0;
    int wait_k;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        line = v;
        repeat (BT) @(negedge clk);
    endtask

    // par < 0 means no parity bit; spike_bit >= 0 puts a 4-clk low spike mid data bit.
    task automatic send(input int dbits, input logic [8:0] data, input int par,
                        input logic stop1, input logic stop2, input int nstop, input int spike_bit);
        bit_out(1'b0);
        for (int i = 0; i < dbits; i++) begin
            if (i == spike_bit) begin
                line = data[i];
                repeat (32) @(negedge clk);
                line = 1'b0;
                repeat (4) @(negedge clk);
                line = data[i];
                repeat (BT - 36) @(negedge clk);
            end else begin
                bit_out(data[i]);
            end
        end
        if (par >= 0) bit_out(par[0]);
        bit_out(stop1);
        if (nstop == 2) bit_out(stop2);
        line = 1'b1;
        repeat (2 * BT) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        line  = 1'b1;
        sel   = 0;
        repeat (4) @(negedge clk);

        // Reset state
        chk_val("rst_dout", dout_a, 0);
        chk_val("rst_done", done_a, 0);
        chk_val("rst_pe",   pe_a,   0);
        chk_val("rst_fe",   fe_a,   0);
        chk_val("rst_brk",  brk_a,  0);
        chk_val("rst_busy", busy_a, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 0x55 8N1, busy low 2 clks after the strobe
        c0 = cnt_a;
        fork
            send(8, 9'h055, -1, 1'b1, 1'b1, 1, -1);
            begin
                wait_k = 0;
                while (done_a !== 1'b1 && wait_k < 1000) begin
                    @(negedge clk);
                    wait_k++;
                end
                chk_val("t1_strobe_seen", (wait_k < 1000), 1);
                repeat (2) @(negedge clk);
                chk_val("t1_busy_after", busy_a, 0);
            end
        join
        chk_val("t1_count", cnt_a - c0, 1);
        chk_val("t1_dout",  dout_a, 8'h55);
        chk_val("t1_pe",    pe_a,   0);
        chk_val("t1_fe",    fe_a,   0);
        chk_val("t1_brk",   brk_a,  0);

        // Start glitch of 3 ticks, then 0xC3
        c0 = cnt_a;
        line = 1'b0;
        repeat (12) @(negedge clk);
        chk_val("t2_busy_in_glitch", busy_a, 1);
        line = 1'b1;
        repeat (3 * BT) @(negedge clk);
        chk_val("t2_busy_idle", busy_a, 0);
        chk_val("t2_no_strobe", cnt_a - c0, 0);
        c0 = cnt_a;
        send(8, 9'h0C3, -1, 1'b1, 1'b1, 1, -1);
        chk_val("t2_count", cnt_a - c0, 1);
        chk_val("t2_dout",  dout_a, 8'hC3);

        // Even parity on instance B: 0xA3 has four ones, so parity bit 1 is wrong
        sel = 1;
        c0 = cnt_b;
        send(8, 9'h0A3, 1, 1'b1, 1'b1, 1, -1);
        chk_val("t3_count_bad", cnt_b - c0, 1);
        chk_val("t3_dout_bad",  dout_b, 8'hA3);
        chk_val("t3_pe_bad",    pe_b,   1);
        chk_val("t3_fe_bad",    fe_b,   0);
        send(8, 9'h0A3, 0, 1'b1, 1'b1, 1, -1);
        chk_val("t3_dout_ok",   dout_b, 8'hA3);
        chk_val("t3_pe_ok",     pe_b,   0);
        sel = 0;

        // Stop bit low on 0x7E
        c0 = cnt_a;
        send(8, 9'h07E, -1, 1'b0, 1'b1, 1, -1);
        chk_val("t4_count", cnt_a - c0, 1);
        chk_val("t4_dout",  dout_a, 8'h7E);
        chk_val("t4_fe",    fe_a,   1);
        chk_val("t4_brk",   brk_a,  0);

        // Break: 12 bit times low
        c0 = cnt_a;
        line = 1'b0;
        repeat (12 * BT) @(negedge clk);
        chk_val("t5_count_low", cnt_a - c0, 1);
        chk_val("t5_busy_held", busy_a, 1);
        chk_val("t5_dout",      dout_a, 0);
        chk_val("t5_brk",       brk_a,  1);
        chk_val("t5_fe",        fe_a,   1);
        line = 1'b1;
        repeat (2 * BT) @(negedge clk);
        chk_val("t5_count_after", cnt_a - c0, 1);
        chk_val("t5_busy_after",  busy_a, 0);
        send(8, 9'h011, -1, 1'b1, 1'b1, 1, -1);
        chk_val("t5_next_dout", dout_a, 8'h11);
        chk_val("t5_next_brk",  brk_a,  0);
        chk_val("t5_next_fe",   fe_a,   0);

        // Single-tick spike mid data bit 3 of 0xFF
        send(8, 9'h0FF, -1, 1'b1, 1'b1, 1, 3);
        chk_val("t6_dout", dout_a, 8'hFF);
        chk_val("t6_fe",   fe_a,   0);

        // Reset mid data bit 4 of 0xF0 on instance A
        c0 = cnt_a;
        fork
            send(8, 9'h0F0, -1, 1'b1, 1'b1, 1, -1);
            begin
                repeat (5 * BT + 32) @(negedge clk);
                reset = 1'b0;
                #1;
                chk_val("t7_rst_dout", dout_a, 0);
                chk_val("t7_rst_busy", busy_a, 0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        chk_val("t7_no_strobe", cnt_a - c0, 0);
        c0 = cnt_a;
        send(8, 9'h096, -1, 1'b1, 1'b1, 1, -1);
        chk_val("t7_count", cnt_a - c0, 1);
        chk_val("t7_dout",  dout_a, 8'h96);

        // Instance C: DBIT=7, two stop bits
        sel = 2;
        send(7, 9'h02A, -1, 1'b1, 1'b1, 2, -1);
        chk_val("t8_dout", dout_c, 7'h2A);
        chk_val("t8_fe",   fe_c,   0);
        send(7, 9'h055, -1, 1'b1, 1'b0, 2, -1);
        chk_val("t8_stop2_dout", dout_c, 7'h55);
        chk_val("t8_stop2_fe",   fe_c,   1);
        chk_val("t8_stop2_brk",  brk_c,  0);
        c0 = cnt_c;
        fork
            send(7, 9'h070, -1, 1'b1, 1'b1, 2, -1);
            begin
                repeat (5 * BT + 32) @(negedge clk);
                reset = 1'b0;
                #1;
                chk_val("t8_rst_dout", dout_c, 0);
                chk_val("t8_rst_fe",   fe_c,   0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        chk_val("t8_no_strobe", cnt_c - c0, 0);
        c0 = cnt_c;
        send(7, 9'h096, -1, 1'b1, 1'b1, 2, -1);
        chk_val("t8_count", cnt_c - c0, 1);
        chk_val("t8_dout2", dout_c, 7'h16);
        chk_val("t8_fe2",   fe_c,   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
